mux4p1_rr: RTL and testbench
============================

# mux4p1_rr

Four-channel round-robin multiplexer: merges four valid/ready input streams onto one registered output stream and tags each word with its source channel index. It is the collecting counterpart of the 1-to-4 demultiplexer. The `out_sel` tag is sized to drive that demux's `sel` directly, so a word can be routed back to the lane it came from.

## Interface
Parameters:
- `WIDTH`, default 8: data width per channel.

Ports:
- `clk` input 1: system clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 4: bit i means channel i presents a word.
- `in_data` input 4*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_ready` output 4: one-hot (or zero) grant. Bit i high means channel i transfers this cycle.
- `out_valid` output 1: output register holds a word.
- `out_ready` input 1: downstream accepts the output word.
- `out_data` output WIDTH: registered output word.
- `out_sel` output 2: index of the channel that supplied `out_data`.

## Operation
- Transfer occurs on any port when valid && ready are both high at a rising edge.
- Internal state:
  - one-entry output register (`out_valid`, `out_data`, `out_sel`)
  - 2-bit round-robin pointer `ptr`
- `can_load = !out_valid || out_ready`. This is true when the register is empty or is being drained this cycle.
- Arbitration is combinational. When `can_load` is true, the granted channel g is the first set bit of `in_valid` searched in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- `in_ready` = one-hot(g) when `can_load` and any `in_valid` bit is set; otherwise `in_ready` = 4'b0000.
- `in_ready` may depend on `in_valid`. No `in_valid` bit may depend on `in_ready`.
- On a grant at a clock edge:
  - `out_data` <= word of channel g
  - `out_sel` <= g
  - `out_valid` <= 1
  - `ptr` <= (g + 1) mod 4
- If `can_load` is true and no channel is valid:
  - `out_valid` <= 0
  - `out_data`, `out_sel` and `ptr` hold their values
- If `out_valid` && !`out_ready`:
  - all state holds
  - `in_ready` = 0000
- `ptr` advances only on a grant. Idle cycles never move it.
- Fairness: a channel that holds `in_valid` high is granted within 4 output transfers.

## Timing
- Reset (`rst`=1 at an edge):
  - `out_valid`=0, `out_data`=0, `out_sel`=2'b00, `ptr`=0
  - `in_ready`=0000 while `rst` is high
- Reset mid-operation discards any held word. No transfer is reported in a cycle where `rst` is high.
- Latency: an input transfer at edge N produces `out_valid`=1 with that word at edge N, visible in cycle N+1.
- Throughput: one word per cycle while `out_ready` stays high. Draining and reloading happen at the same edge, with no bubble.
- Wrap-around: `ptr`=3 and a grant to channel 3 sets `ptr`=0. A search starting at 3 checks 3, 0, 1, 2.
- Simultaneous drain and load: the old word is consumed and the new word is loaded at the same edge. `out_valid` stays 1.
- Once `out_valid` is high, `out_data` and `out_sel` are stable until `out_ready` is sampled high.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with all `in_valid`=1111 → `out_valid`=0, `out_data`=0, `out_sel`=00, `in_ready`=0000 throughout.
- Single channel: after reset, set `in_valid`=0100, ch2 data=8'hA5, `out_ready`=1 → `in_ready`=0100 in the same cycle. Next cycle: `out_valid`=1, `out_data`=8'hA5, `out_sel`=10, `ptr`=3.
- Full load: `in_valid`=1111 continuously, `out_ready`=1, channel i data=8'h10+i → `out_sel` sequence 00,01,10,11,00 and `out_data` sequence 10,11,12,13,10, one word per cycle.
- Backpressure: with `out_valid`=1 (data 8'h11, sel 01), hold `out_ready`=0 for 3 cycles while `in_valid`=1111 → `out_data`/`out_sel` stable and `in_ready`=0000. Raise `out_ready` → `in_ready`=0100 in that cycle, and the next word is 8'h12, sel 10.
- Wrap and skip: after a grant to ch2 (`ptr`=3), set `in_valid`=1001 → grants ch3, then ch0 (`out_sel` 11 then 00). Then set `in_valid`=0000 with `out_ready`=1 → `out_valid` drops to 0 and `ptr` stays at 1.
- Reset mid-stream: assert `rst` for 1 cycle while `out_valid`=1 and `in_valid`=1111 → next cycle `out_valid`=0 and `out_sel`=00. After release, the first grant goes to ch0.

Source files
------------

// File: rtl/mux4p1_rr.sv
// mux4p1_rr: four-channel round-robin merge onto one registered stream.
// Each output word carries the index of the lane that supplied it.
module mux4p1_rr #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_sel;
  logic [1:0]       r_ptr;

  logic             w_can_load;
  logic             w_hit;
  logic [1:0]       w_gnt;
  logic             w_load;
  logic [WIDTH-1:0] w_word;

  assign w_can_load = !r_valid || out_ready;

  // Scan from ptr+3 down to ptr so the nearest valid lane wins.
  always_comb begin
    w_hit = 1'b0;
    w_gnt = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (in_valid[r_ptr + 2'(k)]) begin
        w_hit = 1'b1;
        w_gnt = r_ptr + 2'(k);
      end
    end
  end

  assign w_load = !rst && w_can_load && w_hit;
  assign w_word = in_data[int'(w_gnt)*WIDTH +: WIDTH];

  always_comb begin
    in_ready = 4'b0000;
    if (w_load) begin
      in_ready[w_gnt] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= 2'b00;
      r_ptr   <= 2'b00;
    end else if (w_can_load) begin
      if (w_hit) begin
        r_valid <= 1'b1;
        r_data  <= w_word;
        r_sel   <= w_gnt;
        r_ptr   <= w_gnt + 2'd1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_mux4p1_rr.sv
// tb_mux4p1_rr: scoreboard bench for the round-robin 4:1 merge.
// Queue holds the word the output register should present.
module tb_mux4p1_rr;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   sel;
  } word_t;

  logic           clk;
  logic           rst;
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;

  mux4p1_rr #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sel  (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  word_t      sb[$];
  logic [1:0] m_ptr = 2'd0;
  logic [W-1:0] d[4];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive, check comb + registered outputs, advance model.
  task automatic step(input logic [3:0] v,
                      input logic rdy,
                      input logic r);
    logic       hit;
    logic [1:0] g;
    logic [1:0] c;
    logic       can;
    logic [3:0] er;
    word_t      w;
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    out_ready = rdy;
    in_data   = {d[3], d[2], d[1], d[0]};
    #1;
    hit = 1'b0;
    g   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      c = m_ptr + 2'(k);
      if (!hit && v[c]) begin
        hit = 1'b1;
        g   = c;
      end
    end
    can = (sb.size() == 0) || rdy;
    er  = (!r && can && hit) ? (4'b0001 << g) : 4'b0000;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("out_data", 32'(out_data), 32'(sb[0].data));
      chk("out_sel", 32'(out_sel), 32'(sb[0].sel));
    end
    if (r) begin
      sb.delete();
      m_ptr = 2'd0;
    end else if (can) begin
      if (sb.size() != 0) void'(sb.pop_front());
      if (hit) begin
        w.data = d[g];
        w.sel  = g;
        sb.push_back(w);
        m_ptr = g + 2'd1;
      end
    end
  endtask

  task automatic set_ramp(input logic [W-1:0] base);
    for (int i = 0; i < 4; i++) d[i] = base + W'(i);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    set_ramp(8'h10);
    in_data   = {d[3], d[2], d[1], d[0]};

    // reset held with all lanes valid
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_sel", 32'(out_sel), 32'h0);

    // single channel
    set_ramp(8'h00);
    d[2] = 8'hA5;
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // full load from ptr 0
    step(4'b0000, 1'b1, 1'b1);
    set_ramp(8'h10);
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b1, 1'b0);

    // backpressure holding 11/01
    step(4'b0000, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // wrap 3 -> 0, idle keeps ptr
    step(4'b1001, 1'b1, 1'b0);
    step(4'b1001, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);

    // reset mid-stream
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b0);
    chk("mid_rst_sel", 32'(out_sel), 32'h0);
    step(4'b1111, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 200; i++) begin
      for (int j = 0; j < 4; j++) d[j] = W'($urandom);
      step(4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0), 1'b0);
    end

    // drain
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
